// File: rtl/seg7_capture.sv
// Captures a multiplexed 8-digit seven-segment display into a decoded frame.
// Inputs are synchronized, debounced and published per complete or timed-out scan.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  AN,
    input  logic [7:0]  D7S,
    output logic [39:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  present,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(FRAME_TIMEOUT - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam logic [4:0] BLANK = 5'b10001;
    localparam logic [4:0] BAD   = 5'b11111;

    logic [15:0]   sync1;
    logic [15:0]   sync2;
    logic [15:0]   prev;
    logic [SW-1:0] stab;
    logic [SW-1:0] stab_n;
    logic          change;
    logic          accept;

    logic [7:0] an_s;
    logic [7:0] seg_s;
    logic [7:0] nz;
    logic       multi;
    logic [7:0] cap_mask;
    logic       capture;
    logic [4:0] code;

    logic [0:0]    state;
    logic [7:0]    seen;
    logic [7:0]    seen_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] icnt;
    logic [4:0]    w_dig   [8];
    logic [4:0]    w_dig_n [8];
    logic [7:0]    w_dp;
    logic [7:0]    w_dp_n;
    logic [39:0]   pub_dig;
    logic [7:0]    pub_dp;
    logic          full;
    logic          tout;
    logic          idle_tout;
    logic          publish;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] c;
        case (p)
            7'h40:   c = 5'h0;
            7'h79:   c = 5'h1;
            7'h24:   c = 5'h2;
            7'h30:   c = 5'h3;
            7'h19:   c = 5'h4;
            7'h12:   c = 5'h5;
            7'h02:   c = 5'h6;
            7'h78:   c = 5'h7;
            7'h00:   c = 5'h8;
            7'h10:   c = 5'h9;
            7'h08:   c = 5'hA;
            7'h03:   c = 5'hB;
            7'h46:   c = 5'hC;
            7'h21:   c = 5'hD;
            7'h06:   c = 5'hE;
            7'h0E:   c = 5'hF;
            7'h7F:   c = BLANK;
            default: c = BAD;
        endcase
        return c;
    endfunction

    // Accept once per stable run: the counter saturates at S_MAX.
    always_comb begin
        change = (sync2 != prev);
        stab_n = stab;
        if (change) begin
            stab_n = '0;
        end else if (stab != S_MAX) begin
            stab_n = stab + 1'b1;
        end
        accept = (stab_n == S_MAX) && (change || stab != S_MAX);
    end

    always_comb begin
        an_s     = sync2[15:8];
        seg_s    = sync2[7:0];
        nz       = ~an_s;
        multi    = (nz & (nz - 8'd1)) != 8'd0;
        cap_mask = (accept && !multi) ? nz : 8'd0;
        capture  = |cap_mask;
        code     = decode(seg_s[6:0]);
    end

    always_comb begin
        seen_n = seen | cap_mask;
        w_dp_n = w_dp;
        for (int i = 0; i < 8; i++) begin
            w_dig_n[i] = w_dig[i];
            if (cap_mask[i]) begin
                w_dig_n[i] = code;
                w_dp_n[i]  = ~seg_s[7];
            end
        end
        pub_dig = '0;
        for (int i = 0; i < 8; i++) begin
            pub_dig[5*i +: 5] = seen_n[i] ? w_dig_n[i] : BLANK;
        end
        pub_dp = seen_n & w_dp_n;
    end

    // A capture landing in the publish cycle belongs to the closing frame.
    always_comb begin
        full      = (seen_n == 8'hFF);
        tout      = (tcnt == T_LAST);
        idle_tout = !capture && (icnt == T_LAST);
        publish   = (state == COLLECT) ? (full || tout) : idle_tout;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
            stab  <= '0;
        end else begin
            sync1 <= {AN, D7S};
            sync2 <= sync1;
            prev  <= sync2;
            stab  <= stab_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            seen        <= '0;
            tcnt        <= '0;
            icnt        <= '0;
            w_dp        <= '0;
            digits      <= {8{BLANK}};
            dp          <= '0;
            present     <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                w_dig[i] <= BLANK;
            end
        end else begin
            seg_err     <= capture && (code == BAD);
            an_err      <= accept && multi;
            frame_valid <= publish;
            w_dp        <= w_dp_n;
            for (int i = 0; i < 8; i++) begin
                w_dig[i] <= w_dig_n[i];
            end
            if (publish) begin
                digits  <= pub_dig;
                dp      <= pub_dp;
                present <= seen_n;
                state   <= IDLE;
                seen    <= '0;
                tcnt    <= '0;
                icnt    <= '0;
            end else if (state == IDLE) begin
                tcnt <= '0;
                if (capture) begin
                    state <= COLLECT;
                    seen  <= seen_n;
                    icnt  <= '0;
                end else begin
                    icnt <= icnt + 1'b1;
                end
            end else begin
                seen <= seen_n;
                tcnt <= tcnt + 1'b1;
                icnt <= '0;
            end
        end
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required before a sample is accepted.
REQ-002 The block SHALL have parameter FRAME_TIMEOUT, default 200000: clock cycles from frame start after which an incomplete frame is published.
REQ-003 The block SHALL have port clk, input, 1: the single clock, with all logic on the rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 The block SHALL have port AN, input, 8: anode enables, active-low, with bit i selecting digit i.
REQ-006 The block SHALL have port D7S, input, 8: {dp, g, f, e, d, c, b, a}, all active-low.
REQ-007 The block SHALL have port digits, output, 40: the captured frame, with digit i in bits [5i+4:5i].
REQ-008 The block SHALL have port dp, output, 8: the captured decimal points, active-high, with bit i for digit i.
REQ-009 The block SHALL have port present, output, 8: bit i high when digit i was captured in the published frame.
REQ-010 The block SHALL have port frame_valid, output, 1: a one-cycle pulse when digits, dp and present update.
REQ-011 The block SHALL have port seg_err, output, 1: a one-cycle pulse when an accepted sample carries an undecodable pattern.
REQ-012 The block SHALL have port an_err, output, 1: a one-cycle pulse when an accepted sample has more than one AN bit low.

Function
REQ-013 The block SHALL pass AN and D7S through a two-flop synchronizer before any other use.
REQ-014 The block SHALL compare the synchronized {AN, D7S} with its previous value every cycle, and SHALL clear a stability counter to 0 on any change.
REQ-015 The block SHALL accept a sample in the cycle the stability counter reaches STABLE_CYCLES-1, and SHALL accept at most once until {AN, D7S} next changes.
REQ-016 The block SHALL take an accepted sample with AN all ones as idle: no capture, no error, timeout counter still running.
REQ-017 The block SHALL treat an accepted sample with exactly one AN bit low as digit index i = position of the zero.
REQ-018 An accepted sample with two or more AN bits low SHALL pulse an_err for one cycle and SHALL capture nothing.
REQ-019 The block SHALL decode D7S[6:0] with this map: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9, 0x08->A, 0x03->B, 0x46->C, 0x21->D, 0x06->E, 0x0E->F, each as {0, hex}.
REQ-020 The block SHALL decode 0x7F (blank) to code 5'b10001.
REQ-021 Any other pattern SHALL decode to 5'b11111, SHALL still be captured, and SHALL pulse seg_err for one cycle.
REQ-022 On a capture of digit i, the block SHALL write the code into working slot i, write ~D7S[7] into working dp bit i, and set seen[i].
REQ-023 A repeated index within one frame SHALL overwrite that slot with the latest value.
REQ-024 The frame state machine SHALL have two states: IDLE (seen=0, timeout counter held at 0) and COLLECT.
REQ-025 The first capture in IDLE SHALL move the machine to COLLECT with the timeout counter at 0.
REQ-026 In COLLECT the timeout counter SHALL increment every cycle.
REQ-027 When seen reaches 8'hFF, the block SHALL copy the working slots to digits and dp, set present=8'hFF, pulse frame_valid on the next cycle, clear seen, and return to IDLE.
REQ-028 When the timeout counter reaches FRAME_TIMEOUT-1 with seen not full, the block SHALL publish with present=seen and SHALL output 5'b10001 with dp=0 for every slot not seen.
REQ-029 After a timeout publish the block SHALL pulse frame_valid, clear seen, and return to IDLE.
REQ-030 If the capture completing seen=8'hFF occurs in the same cycle as timeout, the block SHALL publish a complete frame with present=8'hFF.
REQ-031 A capture in the publish cycle SHALL count toward the completed frame, and SHALL NOT start the next frame.
REQ-032 In IDLE with no captures, the block SHALL run a separate FRAME_TIMEOUT counter and SHALL publish present=0, all digits 5'b10001, dp=0, with a frame_valid pulse, repeating every FRAME_TIMEOUT cycles.
REQ-033 The block SHALL hold digits, dp and present stable between frame_valid pulses.
REQ-034 Latency from an input change to the slot write SHALL be 2 synchronizer cycles + STABLE_CYCLES.

Reset
REQ-035 While reset=0 at a clock edge, the block SHALL set digits to all 5'b10001, dp=0, present=0, frame_valid=0, seg_err=0 and an_err=0.
REQ-036 While reset=0 at a clock edge, the block SHALL clear the synchronizers to all ones, clear seen, clear all counters, and set the state to IDLE.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame, and SHALL NOT pulse frame_valid.

Verification
REQ-038 The bench SHALL scan digits 0..7 showing 1,2,3,4,5,6,7,8, 10 cycles each -> one frame_valid with digits=0x08,0x07,...,0x01 (digit0=1), present=0xFF, dp=0.
REQ-039 The bench SHALL drive AN=0xFE, D7S=0x7F with dp low (0x7F & ~0x80) -> dp[0]=1 and digit0=5'b10001 in the next frame.
REQ-040 The bench SHALL give digit 3 a 2-cycle glitch at pattern 0x00 and then 0x30 -> digit3=3, and no capture of 8.
REQ-041 The bench SHALL drive D7S=0x55 on digit 4 -> seg_err pulses once and digit4=5'b11111 in the frame.
REQ-042 The bench SHALL drive AN=0xFC stable -> an_err pulses once, with no capture.
REQ-043 The bench SHALL scan only digits 0,1,3,4,6,7 (FRAME_TIMEOUT=500) -> frame_valid at timeout, present=0xDB, digits 2 and 5 = 5'b10001.
